// File: rtl/cpu7_ifu_ibuf.sv
// cpu7_ifu_ibuf: in-order instruction buffer between fetch and decode, flushed on branch redirect.
// Storage is unreset; occupancy, pointers and the overflow flag clear asynchronously.
module cpu7_ifu_ibuf #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fdp_ibuf_valid,
    input  logic [31:0]              fdp_ibuf_inst,
    input  logic [PC_W-1:0]          fdp_ibuf_pc,
    input  logic                     fdp_ibuf_ex,
    input  logic [5:0]               fdp_ibuf_exccode,
    input  logic                     br_cancel,
    input  logic                     dec_ibuf_ready,
    output logic                     ibuf_dec_valid,
    output logic [31:0]              ibuf_dec_inst,
    output logic [PC_W-1:0]          ibuf_dec_pc,
    output logic                     ibuf_dec_ex,
    output logic [5:0]               ibuf_dec_exccode,
    output logic                     ibuf_ifu_stall_req,
    output logic [$clog2(DEPTH):0]   ibuf_count,
    output logic                     ibuf_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 32 + PC_W + 7;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [EW-1:0] head;
    logic          full, empty, push, pop;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign push  = fdp_ibuf_valid & ~full & ~br_cancel;
    assign pop   = ~empty & dec_ibuf_ready & ~br_cancel;

    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= {fdp_ibuf_ex, fdp_ibuf_exccode, fdp_ibuf_pc, fdp_ibuf_inst};

    // Overflow is registered so it pulses the cycle after the dropped entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ibuf_ovf <= 1'b0;
        end else if (br_cancel) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ibuf_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            ibuf_ovf <= fdp_ibuf_valid & full;
        end
    end

    assign head               = empty ? '0 : mem[rd_ptr];
    assign ibuf_dec_valid     = ~empty;
    assign ibuf_ifu_stall_req = full;
    assign ibuf_count         = count;
    assign {ibuf_dec_ex, ibuf_dec_exccode, ibuf_dec_pc, ibuf_dec_inst} = head;
endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// tb_cpu7_ifu_ibuf: directed self-checking bench for the instruction buffer.
module tb_cpu7_ifu_ibuf;
    logic        clock = 1'b0, reset = 1'b0;
    logic        fdp_ibuf_valid = 1'b0, fdp_ibuf_ex = 1'b0, br_cancel = 1'b0, dec_ibuf_ready = 1'b0;
    logic [31:0] fdp_ibuf_inst = '0, fdp_ibuf_pc = '0;
    logic [5:0]  fdp_ibuf_exccode = '0;
    logic        ibuf_dec_valid, ibuf_dec_ex, ibuf_ifu_stall_req, ibuf_ovf;
    logic [31:0] ibuf_dec_inst, ibuf_dec_pc;
    logic [5:0]  ibuf_dec_exccode;
    logic [2:0]  ibuf_count;
    int tests = 0, fails = 0;

    cpu7_ifu_ibuf #(.DEPTH(4), .PC_W(32)) dut (
        .clock(clock), .reset(reset),
        .fdp_ibuf_valid(fdp_ibuf_valid), .fdp_ibuf_inst(fdp_ibuf_inst), .fdp_ibuf_pc(fdp_ibuf_pc),
        .fdp_ibuf_ex(fdp_ibuf_ex), .fdp_ibuf_exccode(fdp_ibuf_exccode),
        .br_cancel(br_cancel), .dec_ibuf_ready(dec_ibuf_ready),
        .ibuf_dec_valid(ibuf_dec_valid), .ibuf_dec_inst(ibuf_dec_inst), .ibuf_dec_pc(ibuf_dec_pc),
        .ibuf_dec_ex(ibuf_dec_ex), .ibuf_dec_exccode(ibuf_dec_exccode),
        .ibuf_ifu_stall_req(ibuf_ifu_stall_req), .ibuf_count(ibuf_count), .ibuf_ovf(ibuf_ovf)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction word is derived from the PC so the pairing can be checked too.
    task automatic drive(input logic v, input logic [31:0] pc, input logic ex, input logic [5:0] code,
                         input logic cancel, input logic rdy);
        fdp_ibuf_valid   = v;
        fdp_ibuf_pc      = pc;
        fdp_ibuf_inst    = pc ^ 32'h5A5A_0000;
        fdp_ibuf_ex      = ex;
        fdp_ibuf_exccode = code;
        br_cancel        = cancel;
        dec_ibuf_ready   = rdy;
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic ex, input logic [5:0] code);
        chk({tag, "_valid"}, 64'(ibuf_dec_valid), 64'd1);
        chk({tag, "_pc"}, 64'(ibuf_dec_pc), 64'(pc));
        chk({tag, "_inst"}, 64'(ibuf_dec_inst), 64'(pc ^ 32'h5A5A_0000));
        chk({tag, "_ex"}, 64'(ibuf_dec_ex), 64'(ex));
        chk({tag, "_code"}, 64'(ibuf_dec_exccode), 64'(code));
    endtask

    initial begin
        // T1 reset with random inputs
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        chk("rst_valid", 64'(ibuf_dec_valid), 64'd0);
        chk("rst_count", 64'(ibuf_count), 64'd0);
        chk("rst_stall", 64'(ibuf_ifu_stall_req), 64'd0);
        chk("rst_ovf", 64'(ibuf_ovf), 64'd0);
        chk("rst_pc", 64'(ibuf_dec_pc), 64'd0);
        chk("rst_inst", 64'(ibuf_dec_inst), 64'd0);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        chk("rel_valid", 64'(ibuf_dec_valid), 64'd0);
        chk("rel_count", 64'(ibuf_count), 64'd0);

        // T2 fill then drain
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1C00_0000 + 32'(4*i), 0, 0, 0, 0);
            step();
            chk("fill_count", 64'(ibuf_count), 64'(i + 1));
            chk("fill_stall", 64'(ibuf_ifu_stall_req), 64'(i == 3));
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            head("drain", 32'h1C00_0000 + 32'(4*i), 0, 0);
            step();
            chk("drain_count", 64'(ibuf_count), 64'(3 - i));
            chk("drain_stall", 64'(ibuf_ifu_stall_req), 64'd0);
        end
        chk("drain_empty", 64'(ibuf_dec_valid), 64'd0);
        chk("drain_pc0", 64'(ibuf_dec_pc), 64'd0);

        // T3 streaming push+pop each cycle
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'h1C00_1000 + 32'(4*i), 0, 0, 0, 1);
            step();
            chk("stream_count", 64'(ibuf_count), 64'd1);
            chk("stream_pc", 64'(ibuf_dec_pc), 64'(32'h1C00_1000 + 32'(4*i)));
        end
        drive(0, 0, 0, 0, 0, 1);
        step();
        chk("stream_end", 64'(ibuf_count), 64'd0);

        // T4 flush with concurrent push and ready
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1C00_0200 + 32'(4*i), 0, 0, 0, 0);
            step();
        end
        chk("pre_flush", 64'(ibuf_count), 64'd3);
        drive(1, 32'h1C00_02F0, 0, 0, 1, 1);
        step();
        chk("flush_valid", 64'(ibuf_dec_valid), 64'd0);
        chk("flush_count", 64'(ibuf_count), 64'd0);
        chk("flush_ovf", 64'(ibuf_ovf), 64'd0);
        step();
        chk("flush2_count", 64'(ibuf_count), 64'd0);
        drive(1, 32'h1C00_0100, 0, 0, 0, 0);
        step();
        chk("post_flush_count", 64'(ibuf_count), 64'd1);
        head("post_flush", 32'h1C00_0100, 0, 0);

        // T5 overflow: drop while full
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1C00_0300 + 32'(4*i), 0, 0, 0, 0);
            step();
        end
        chk("ovf_full", 64'(ibuf_ifu_stall_req), 64'd1);
        chk("ovf_idle", 64'(ibuf_ovf), 64'd0);
        drive(1, 32'hDEAD_BEEC, 1, 6'h3F, 0, 0);
        step();
        chk("ovf_pulse", 64'(ibuf_ovf), 64'd1);
        chk("ovf_count", 64'(ibuf_count), 64'd4);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("ovf_clear", 64'(ibuf_ovf), 64'd0);
        dec_ibuf_ready = 1'b1;
        head("ovf_h0", 32'h1C00_0100, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            head("ovf_h", 32'h1C00_0300 + 32'(4*i), 0, 0);
            step();
        end
        chk("ovf_drained", 64'(ibuf_count), 64'd0);

        // T6 exception tag travels with its entry
        drive(1, 32'h1C00_0400, 0, 0, 0, 0);
        step();
        drive(1, 32'h1C00_0404, 1, 6'h08, 0, 0);
        step();
        drive(1, 32'h1C00_0408, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1);
        head("ex_a", 32'h1C00_0400, 0, 0);
        step();
        head("ex_b", 32'h1C00_0404, 1, 6'h08);
        step();
        head("ex_c", 32'h1C00_0408, 0, 0);
        step();

        // asynchronous reset mid-operation clears outputs without a clock edge
        drive(1, 32'h1C00_0500, 0, 0, 0, 0);
        step();
        step();
        chk("mid_count", 64'(ibuf_count), 64'd2);
        drive(0, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        chk("async_valid", 64'(ibuf_dec_valid), 64'd0);
        chk("async_count", 64'(ibuf_count), 64'd0);
        reset = 1'b1;
        step();
        chk("async_after", 64'(ibuf_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
